// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 8-channel mux scan sequencer.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;

  localparam logic [SEL_W-1:0] LAST_CH = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

endpackage

// File: rtl/mux8_scan_capture_if.sv
// Sequencer-side bus: control levels, mux select/output, and the captured word.
// The changed flag exists only when MUX8_SCAN_CHANGE_DETECT_EN is defined.
interface mux8_scan_capture_if;
  import mux_scan_pkg::*;

  logic              start;
  logic              continuous;
  logic [SEL_W-1:0]  sel;
  logic              y;
  logic [NUM_CH-1:0] capture;
  logic              busy;
  logic              done;

`ifdef MUX8_SCAN_CHANGE_DETECT_EN
  logic              changed;

  modport master (
    output start, continuous, y,
    input  sel, capture, busy, done, changed
  );

  modport slave (
    input  start, continuous, y,
    output sel, capture, busy, done, changed
  );
`else
  modport master (
    output start, continuous, y,
    input  sel, capture, busy, done
  );

  modport slave (
    input  start, continuous, y,
    output sel, capture, busy, done
  );
`endif

endinterface

// File: rtl/scan_settle_timer.sv
// Loadable down-counter that holds at zero; zero_o flags the end of a settle window.
module scan_settle_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_value_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_value_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux8_scan_capture.sv
// Steps an external 8:1 mux through channels 0..7, samples y once per channel after a settle
// window and publishes the word atomically. Optional macro: MUX8_SCAN_CHANGE_DETECT_EN.
module mux8_scan_capture
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                clk,
  input  logic                rst,
  mux8_scan_capture_if.slave  bus
);

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255)) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end

  // SETTLE_CYCLES >> CNT_W is nonzero exactly when 2**CNT_W <= SETTLE_CYCLES.
  if ((CNT_W < 1) || ((SETTLE_CYCLES >> CNT_W) != 0)) begin : g_bad_cnt_w
    $error("CNT_W too small: need 2**CNT_W > SETTLE_CYCLES");
  end

  localparam logic [CNT_W-1:0] Reload = CNT_W'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] capture_q, capture_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tmr_load, tmr_en, tmr_zero;

`ifdef MUX8_SCAN_CHANGE_DETECT_EN
  logic              changed_q, changed_d;
`endif

  scan_settle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .load_i       (tmr_load),
    .load_value_i (Reload),
    .en_i         (tmr_en),
    .zero_o       (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    shadow_d  = shadow_q;
    capture_d = capture_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
`ifdef MUX8_SCAN_CHANGE_DETECT_EN
    changed_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = SETTLE;
          sel_d    = '0;
          tmr_load = 1'b1;
        end
      end

      SETTLE: begin
        if (tmr_zero) begin
          state_d = SAMPLE;
        end else begin
          tmr_en = 1'b1;
        end
      end

      SAMPLE: begin
        shadow_d[sel_q] = bus.y;
        if (sel_q == LAST_CH) begin
          // Publish on the same edge as done rises so capture and done stay aligned.
          state_d   = DONE;
          capture_d = shadow_d;
          done_d    = 1'b1;
`ifdef MUX8_SCAN_CHANGE_DETECT_EN
          changed_d = (shadow_d != capture_q);
`endif
        end else begin
          state_d  = SETTLE;
          sel_d    = sel_q + 1'b1;
          tmr_load = 1'b1;
        end
      end

      DONE: begin
        sel_d = '0;
        if (bus.continuous) begin
          state_d  = SETTLE;
          tmr_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      shadow_q  <= '0;
      capture_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      shadow_q  <= shadow_d;
      capture_q <= capture_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef MUX8_SCAN_CHANGE_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign bus.changed = changed_q;
`endif

  assign bus.sel     = sel_q;
  assign bus.capture = capture_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_mux8_scan_capture.sv
// Randomized and directed bench for mux8_scan_capture against a timing-level scan model.
module tb_mux8_scan_capture;

  localparam int S    = 2;
  localparam int CH_T = S + 1;
  localparam int SCAN = 8 * CH_T;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'hA5;

  int n_cmp = 0;
  int n_bad = 0;

  mux8_scan_capture_if bus ();

  mux8_scan_capture #(
    .SETTLE_CYCLES (S),
    .CNT_W         (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.y = data[bus.sel];

  always #5 clk = ~clk;

  // Scan model: m_t counts edges since the scan began; channel k is sampled at edge (k+1)*CH_T.
  bit         m_act = 1'b0;
  int         m_t = 0;
  logic [7:0] m_word = 8'h00;
  logic [7:0] m_cap = 8'h00;
  logic [7:0] m_prev = 8'h00;
  bit         chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!bus.done && cycles < 100);
  endtask

  initial begin
    int         ch;
    logic [2:0] chb;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_act  = 1'b0;
        m_t    = 0;
        m_cap  = 8'h00;
        m_prev = 8'h00;
      end else if (!m_act) begin
        if (bus.start) begin
          m_act = 1'b1;
          m_t   = 0;
        end
      end else if (m_t == SCAN) begin
        if (bus.continuous) m_t = 0;
        else m_act = 1'b0;
      end else begin
        m_t++;
        if (m_t % CH_T == 0) begin
          ch  = m_t / CH_T - 1;
          chb = 3'(ch);
          m_word[chb] = data[chb];
        end
        if (m_t == SCAN) begin
          m_prev = m_cap;
          m_cap  = m_word;
        end
      end
    end
  end

  initial begin
    int e_sel;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_sel = !m_act ? 0 : ((m_t >= SCAN) ? 7 : m_t / CH_T);
        check("cyc_sel", 32'(bus.sel), e_sel);
        check("cyc_busy", 32'(bus.busy), 32'(m_act));
        check("cyc_done", 32'(bus.done), 32'(m_act && m_t == SCAN));
        check("cyc_capture", 32'(bus.capture), 32'(m_cap));
`ifdef MUX8_SCAN_CHANGE_DETECT_EN
        check("cyc_changed", 32'(bus.changed), 32'(m_act && m_t == SCAN && m_cap != m_prev));
`endif
      end
    end
  end

  initial begin
    int  c;
    bit  found;
    bus.start      = 1'b0;
    bus.continuous = 1'b0;

    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_sel", 32'(bus.sel), 0);
    check("rst_capture", 32'(bus.capture), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    chk_en = 1'b1;

    // Single scan
    data = 8'hA5;
    pulse_start();
    wait_done(c);
    check("single_latency", c, 24);
    check("single_capture", 32'(bus.capture), 32'h A5);
    step();
    check("single_busy_after", 32'(bus.busy), 0);
    step();

    // Sampling instant: glitch confined to channel 3 settle, then held through its sample
    for (int pass = 0; pass < 2; pass++) begin
      data = 8'h00;
      pulse_start();
      c = 0;
      do begin
        step();
        c++;
        if (c == 9) data[3] = 1'b1;
        if (c == 11 + pass) data[3] = 1'b0;
      end while (!bus.done && c < 100);
      check("glitch_capture", 32'(bus.capture), (pass == 0) ? 32'h00 : 32'h08);
      step();
    end

    // Continuous mode
    data = 8'h3C;
    bus.continuous = 1'b1;
    pulse_start();
    wait_done(c);
    check("cont_first_lat", c, 24);
    check("cont_first_cap", 32'(bus.capture), 32'h3C);
    data = 8'hC3;
    wait_done(c);
    check("cont_period", c, 25);
    check("cont_second_cap", 32'(bus.capture), 32'hC3);
    bus.continuous = 1'b0;
    step();
    check("cont_stop_busy", 32'(bus.busy), 0);

    // start ignored while busy
    data = 8'h96;
    pulse_start();
    c = 0;
    do begin
      step();
      c++;
      bus.start = (c == 5);
    end while (!bus.done && c < 100);
    bus.start = 1'b0;
    check("ignore_latency", c, 24);
    check("ignore_capture", 32'(bus.capture), 32'h96);
    step();
    step();

    // Abort with reset at sel=5
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.sel == 3'd5) found = 1'b1;
      else step();
    end
    check("abort_reach_sel5", 32'(found), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_capture", 32'(bus.capture), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_sel", 32'(bus.sel), 0);

`ifdef MUX8_SCAN_CHANGE_DETECT_EN
    // Change detect against the previous word (capture is 0 after the abort)
    for (int i = 0; i < 3; i++) begin
      data = (i == 2) ? 8'h5B : 8'h5A;
      pulse_start();
      wait_done(c);
      check("chg_flag", 32'(bus.changed), (i == 1) ? 0 : 1);
      step();
    end
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step();
      data           = 8'($urandom);
      bus.start      = ($urandom_range(0, 3) == 0);
      bus.continuous = ($urandom_range(0, 1) == 1);
      rst            = ($urandom_range(0, 299) == 0);
    end
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    repeat (40) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux8_scan_capture.md
Name: mux8_scan_capture

Overview:
- Sequencer that sits around the 8:1 mux.
- Drives the mux `sel` bus through channels 0..7 and waits a programmable settle time on each channel.
- Samples the mux `y` output and assembles the eight samples into one parallel 8-bit word.
- Used on Basys 3 to read eight mux-selected signals (switches or status bits) as one word for LEDs or downstream logic.

Parameters:
- SETTLE_CYCLES, 2: cycles `sel` is held stable before `y` is sampled. Legal range 1..255; 0 is illegal and must fail elaboration.
- CNT_W, 8: width of the settle counter. Must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level; sampled only in IDLE; begins one scan.
- continuous  input  1  level; when high, the scan restarts from DONE without passing through IDLE.
- sel  output  3  registered channel select; drives the mux `sel`.
- y  input  1  mux output for the current `sel`.
- capture  output  8  last completed scan word; capture[k] = y sampled while sel=k.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when `capture` updates.
- changed  output  1  present only with CHANGE_DETECT_EN (see Optional Feature).

Behaviour:
- Reset is synchronous and active-high on `clk`. Outputs after reset: sel=0, capture=8'h00, busy=0, done=0, changed=0. Internal state: state=IDLE, shadow=8'h00, counter=0.
- States and transitions:
  - IDLE: if start=1, go to SETTLE with sel=0 and counter=SETTLE_CYCLES-1. Otherwise stay.
  - SETTLE: sel held constant. Counter decrements each cycle. When counter=0, go to SAMPLE.
  - SAMPLE (1 cycle): shadow[sel] <= y.
    - If sel=7, go to DONE.
    - Else sel <= sel+1, counter reloads to SETTLE_CYCLES-1, go to SETTLE.
  - DONE (1 cycle): capture <= shadow; done=1.
    - If continuous=1, sel <= 0, reload counter, go to SETTLE.
    - Else sel <= 0, go to IDLE.
- Timing:
  - Each channel takes SETTLE_CYCLES+1 cycles.
  - done is high in the cycle 8*(SETTLE_CYCLES+1) cycles after the cycle in which start was sampled high. With the default SETTLE_CYCLES=2 this is 24 cycles.
  - Back-to-back period in continuous mode is 8*(SETTLE_CYCLES+1)+1 cycles.
- `capture` changes only at the DONE edge. It is never partially updated, so it is stable and valid whenever done=0.
- `y` is sampled exactly once per channel, at the SAMPLE edge. Changes on `y` during SETTLE have no effect.
- start is ignored while busy=1. start held high in IDLE restarts a scan every time IDLE is entered.
- continuous is read only in DONE. Dropping it mid-scan lets the current scan finish and then return to IDLE.
- rst asserted mid-scan aborts immediately to the reset values: no done pulse, and `capture` is cleared to 8'h00.
- sel wraps 7→0 only via DONE; it never increments past 7.

Optional Feature:
- Macro: MUX8_SCAN_CHANGE_DETECT_EN.
- Defined:
  - Port `changed` exists.
  - In DONE, changed=1 for that one cycle if shadow != capture (the previous word), else 0.
  - The first scan after reset compares against 8'h00.
- Undefined:
  - `changed` port and its compare logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package mux_scan_pkg:
  - state enum IDLE/SETTLE/SAMPLE/DONE.
  - NUM_CH=8, SEL_W=3.
  - LAST_CH=3'd7.
- Sub-module scan_settle_timer:
  - Loadable down-counter of width CNT_W.
  - Inputs: load, load_value, en.
  - Output: zero flag.
  - The top FSM instantiates it once.

Test Plan:
- Reset check: bench mux y=data[sel] with data=8'hA5. Assert rst for 2 cycles, then release → sel=0, capture=0, busy=0, done=0.
- Single scan: data=8'hA5, pulse start for 1 cycle → sel steps 0..7, each value held 3 cycles. done pulses exactly 24 cycles after start. capture=8'hA5. busy falls the cycle after done.
- Sampling instant: data=8'h00, toggle data[3] to 1 only during SETTLE of channel 3, then restore to 0 before SAMPLE → capture[3]=0. Hold data[3] high through the SAMPLE cycle → capture[3]=1.
- Continuous mode: continuous=1, data=8'h3C, then 8'hC3 during the second scan → successive done pulses 25 cycles apart. capture goes 3C then C3, with no intermediate values.
- Abort and ignore: pulse start during a scan → ignored, and done still occurs 24 cycles after the first start. rst at sel=5 → capture=0, no done, IDLE the next cycle.
- With MUX8_SCAN_CHANGE_DETECT_EN: scans of data 8'h5A, 8'h5A, 8'h5B → changed=1, 0, 1, each asserted on its done cycle.
